// File: rtl/zvc_stream_packer.sv
// Packs variable-length compressed lines into fixed OUT_WORDS-lane beats.
// Optional flush of a final partial beat: define ZVC_PACKER_FLUSH_EN.
module zvc_stream_packer #(
    parameter int WORD_WIDTH    = 8,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 4,
    parameter int OUT_WORDS     = 32,
    parameter int BUF_WORDS     = 256
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [7:0]                                   in_cnt,
    input  logic [128*WORD_WIDTH-1:0]                    lifm_comp,
    input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]      mt_comp,
    output logic                                         out_valid,
    input  logic                                         out_ready,
`ifdef ZVC_PACKER_FLUSH_EN
    input  logic                                         flush,
`endif
    output logic [$clog2(OUT_WORDS+1)-1:0]               out_cnt,
    output logic [OUT_WORDS*WORD_WIDTH-1:0]              out_lifm,
    output logic [OUT_WORDS*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] out_mt
);

    localparam int IN_WORDS = 128;
    localparam int MT_W     = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int CNT_W    = $clog2(OUT_WORDS + 1);
    localparam logic [8:0] OCC_OUT = 9'(OUT_WORDS);
    localparam logic [8:0] OCC_LIM = 9'(BUF_WORDS - IN_WORDS);
    localparam logic [8:0] IN_MAX  = 9'(IN_WORDS);

    typedef enum logic {
        ST_FILL,
        ST_FLUSH
    } state_t;

    state_t state_q, state_d;

    logic [BUF_WORDS*WORD_WIDTH-1:0] lifm_q, lifm_d, lifm_sh, lifm_ins;
    logic [BUF_WORDS*MT_W-1:0]       mt_q, mt_d, mt_sh, mt_ins;
    logic [BUF_WORDS-1:0]            wmask;
    logic [IN_WORDS-1:0]             lane_en;
    logic [8:0]                      occ_q, occ_d;
    logic [8:0]                      pop_n, base, n;
    logic                            push, pop, flush_pend, flush_req;

`ifdef ZVC_PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign flush_pend = (state_q == ST_FLUSH);

    // Handshake flags come from registered state only.
    assign in_ready  = (occ_q <= OCC_LIM) && !flush_pend;
    assign out_valid = (occ_q >= OCC_OUT) || (flush_pend && occ_q != 9'd0);

    assign pop  = out_valid && out_ready;
    assign push = in_valid && in_ready;

    assign pop_n = !pop ? 9'd0 : (occ_q >= OCC_OUT) ? OCC_OUT : occ_q;
    assign base  = occ_q - pop_n;
    assign n     = !push ? 9'd0 :
                   ({1'b0, in_cnt} > IN_MAX) ? IN_MAX : {1'b0, in_cnt};
    assign occ_d = base + n;

    always_comb begin
        lane_en  = '0;
        lifm_ins = '0;
        mt_ins   = '0;
        for (int i = 0; i < IN_WORDS; i++) begin
            lane_en[i] = (9'(i) < n);
            if (lane_en[i]) begin
                lifm_ins[i*WORD_WIDTH +: WORD_WIDTH] =
                    lifm_comp[i*WORD_WIDTH +: WORD_WIDTH];
                mt_ins[i*MT_W +: MT_W] = mt_comp[i*MT_W +: MT_W];
            end
        end
        lifm_ins = lifm_ins << (base * WORD_WIDTH);
        mt_ins   = mt_ins << (base * MT_W);
        wmask    = {{(BUF_WORDS-IN_WORDS){1'b0}}, lane_en} << base;
    end

    // Pop shifts zeros into the top, so lanes at or above occ stay zero.
    always_comb begin
        lifm_sh = pop ? (lifm_q >> (OUT_WORDS * WORD_WIDTH)) : lifm_q;
        mt_sh   = pop ? (mt_q >> (OUT_WORDS * MT_W)) : mt_q;
        lifm_d  = lifm_sh;
        mt_d    = mt_sh;
        for (int j = 0; j < BUF_WORDS; j++) begin
            if (wmask[j]) begin
                lifm_d[j*WORD_WIDTH +: WORD_WIDTH] =
                    lifm_ins[j*WORD_WIDTH +: WORD_WIDTH];
                mt_d[j*MT_W +: MT_W] = mt_ins[j*MT_W +: MT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL:
                if (flush_req && occ_q != 9'd0 && occ_d != 9'd0)
                    state_d = ST_FLUSH;
            ST_FLUSH:
                if (occ_d == 9'd0)
                    state_d = ST_FILL;
            default:
                state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FILL;
            occ_q   <= '0;
            lifm_q  <= '0;
            mt_q    <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            lifm_q  <= lifm_d;
            mt_q    <= mt_d;
        end
    end

    assign out_cnt  = !out_valid ? '0 :
                      (occ_q >= OCC_OUT) ? CNT_W'(OUT_WORDS) : occ_q[CNT_W-1:0];
    assign out_lifm = lifm_q[OUT_WORDS*WORD_WIDTH-1:0];
    assign out_mt   = mt_q[OUT_WORDS*MT_W-1:0];

endmodule

// File: tb/tb_zvc_stream_packer.sv
// Randomized bench for zvc_stream_packer against a lane-queue model.
// Flush scenarios compile in with ZVC_PACKER_FLUSH_EN.
module tb_zvc_stream_packer;

    localparam int W   = 8;
    localparam int MTW = 28;
    localparam int OW  = 32;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          in_cnt = '0;
    logic [128*W-1:0]    lifm_comp = '0;
    logic [128*MTW-1:0]  mt_comp = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [5:0]          out_cnt;
    logic [OW*W-1:0]     out_lifm;
    logic [OW*MTW-1:0]   out_mt;
`ifdef ZVC_PACKER_FLUSH_EN
    logic                flush = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;

    bit [7:0]     m_lifm[$];
    bit [MTW-1:0] m_mt[$];
    bit           m_fp;

    zvc_stream_packer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .lifm_comp (lifm_comp),
        .mt_comp   (mt_comp),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ZVC_PACKER_FLUSH_EN
        .flush     (flush),
`endif
        .out_cnt   (out_cnt),
        .out_lifm  (out_lifm),
        .out_mt    (out_mt)
    );

    always #5 clk = ~clk;

    function automatic int m_occ();
        return m_lifm.size();
    endfunction

    function automatic bit m_rdy();
        return (m_occ() <= 128) && !m_fp;
    endfunction

    function automatic bit m_val();
        return (m_occ() >= OW) || (m_fp && m_occ() != 0);
    endfunction

    function automatic logic [5:0] m_cnt();
        if (!m_val()) return 6'd0;
        return (m_occ() < OW) ? 6'(m_occ()) : 6'(OW);
    endfunction

    function automatic logic [OW*W-1:0] m_beat_lifm();
        logic [OW*W-1:0] r = '0;
        for (int i = 0; i < OW; i++)
            if (i < m_occ()) r[i*W +: W] = m_lifm[i];
        return r;
    endfunction

    function automatic logic [OW*MTW-1:0] m_beat_mt();
        logic [OW*MTW-1:0] r = '0;
        for (int i = 0; i < OW; i++)
            if (i < m_occ()) r[i*MTW +: MTW] = m_mt[i];
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef ZVC_PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        m_lifm.delete();
        m_mt.delete();
        m_fp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drives one cycle and advances the model; pat<0 gives random LIFM lanes.
    task automatic step(input bit iv, input int cnt, input bit ordy,
                        input bit fl, input int pat);
        bit acc, pp;
        int occ0, k;
        @(negedge clk);
        in_valid  = iv;
        in_cnt    = cnt[7:0];
        out_ready = ordy;
`ifdef ZVC_PACKER_FLUSH_EN
        flush = fl;
`endif
        for (int i = 0; i < 128; i++) begin
            lifm_comp[i*W +: W] = (pat < 0) ? 8'($urandom) : 8'(pat + i);
            mt_comp[i*MTW +: MTW] = MTW'($urandom);
        end
        acc  = iv && m_rdy();
        pp   = ordy && m_val();
        occ0 = m_occ();
        @(posedge clk);
        if (pp) begin
            k = (occ0 < OW) ? occ0 : OW;
            repeat (k) begin
                void'(m_lifm.pop_front());
                void'(m_mt.pop_front());
            end
        end
        if (acc) begin
            k = (cnt > 128) ? 128 : cnt;
            for (int i = 0; i < k; i++) begin
                m_lifm.push_back(lifm_comp[i*W +: W]);
                m_mt.push_back(mt_comp[i*MTW +: MTW]);
            end
        end
`ifdef ZVC_PACKER_FLUSH_EN
        if (fl && occ0 != 0) m_fp = 1'b1;
        if (m_occ() == 0) m_fp = 1'b0;
`else
        if (fl) m_fp = 1'b0;
`endif
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        step(1, 70, 0, 0, -1);
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL rst_pre_valid got=%b exp=1", out_valid);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        nvec += 4;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_valid got=%b exp=0", out_valid);
        end
        if (out_cnt !== 6'd0) begin
            nerr++;
            $display("FAIL rst_cnt got=%0d exp=0", out_cnt);
        end
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_ready got=%b exp=1", in_ready);
        end
        if (out_lifm !== '0 || out_mt !== '0) begin
            nerr++;
            $display("FAIL rst_data got=%h exp=0", out_lifm);
        end
        m_lifm.delete();
        m_mt.delete();
        m_fp = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_concat();
        do_reset();
        step(1, 20, 1, 0, 'hA0);
        step(1, 20, 1, 0, 'hB0);
        nvec += 6;
        if (out_valid !== 1'b1 || out_cnt !== 6'd32) begin
            nerr++;
            $display("FAIL cat_hdr got=%b/%0d exp=1/32", out_valid, out_cnt);
        end
        if (out_lifm[19*W +: W] !== 8'hB3) begin
            nerr++;
            $display("FAIL cat_l19 got=%h exp=b3", out_lifm[19*W +: W]);
        end
        if (out_lifm[20*W +: W] !== 8'hB0) begin
            nerr++;
            $display("FAIL cat_l20 got=%h exp=b0", out_lifm[20*W +: W]);
        end
        if (out_lifm[31*W +: W] !== 8'hBB) begin
            nerr++;
            $display("FAIL cat_l31 got=%h exp=bb", out_lifm[31*W +: W]);
        end
        if (out_lifm !== m_beat_lifm() || out_mt !== m_beat_mt()) begin
            nerr++;
            $display("FAIL cat_beat got=%h exp=%h", out_lifm, m_beat_lifm());
        end
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL cat_ready got=%b exp=1", in_ready);
        end
        step(0, 0, 1, 0, -1);
        nvec += 2;
        if (out_valid !== 1'b0 || out_cnt !== 6'd0) begin
            nerr++;
            $display("FAIL cat_rem got=%b/%0d exp=0/0", out_valid, out_cnt);
        end
        if (out_lifm[0 +: W] !== 8'hBC) begin
            nerr++;
            $display("FAIL cat_res got=%h exp=bc", out_lifm[0 +: W]);
        end
    endtask

    task automatic test_full();
        int occ;
        do_reset();
        step(1, 128, 0, 0, 'h00);
        nvec++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL full_r128 got=%b exp=1", in_ready);
        end
        step(1, 128, 0, 0, 'h80);
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL full_r256 got=%b exp=0", in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            nvec += 3;
            if (out_valid !== 1'b1) begin
                nerr++;
                $display("FAIL full_valid beat=%0d got=%b exp=1", k, out_valid);
            end
            if (out_lifm[0 +: W] !== 8'(32 * k)) begin
                nerr++;
                $display("FAIL full_order beat=%0d got=%h exp=%h",
                         k, out_lifm[0 +: W], 8'(32 * k));
            end
            if (out_lifm !== m_beat_lifm() || out_mt !== m_beat_mt()) begin
                nerr++;
                $display("FAIL full_beat beat=%0d got=%h", k, out_lifm);
            end
            step(0, 0, 1, 0, -1);
            occ = 256 - 32 * (k + 1);
            nvec++;
            if (in_ready !== (occ <= 128)) begin
                nerr++;
                $display("FAIL full_ready beat=%0d got=%b exp=%b",
                         k, in_ready, occ <= 128);
            end
        end
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL full_empty got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 40, 0, 0, 'h10);
        step(1, 50, 1, 0, 'h80);
        nvec += 5;
        if (out_valid !== 1'b1 || out_cnt !== 6'd32) begin
            nerr++;
            $display("FAIL b2b_hdr got=%b/%0d exp=1/32", out_valid, out_cnt);
        end
        if (out_lifm[7*W +: W] !== 8'h37) begin
            nerr++;
            $display("FAIL b2b_l7 got=%h exp=37", out_lifm[7*W +: W]);
        end
        if (out_lifm[8*W +: W] !== 8'h80) begin
            nerr++;
            $display("FAIL b2b_l8 got=%h exp=80", out_lifm[8*W +: W]);
        end
        if (out_lifm[31*W +: W] !== 8'h97) begin
            nerr++;
            $display("FAIL b2b_l31 got=%h exp=97", out_lifm[31*W +: W]);
        end
        if (out_lifm !== m_beat_lifm() || out_mt !== m_beat_mt()) begin
            nerr++;
            $display("FAIL b2b_beat got=%h exp=%h", out_lifm, m_beat_lifm());
        end
        step(0, 0, 1, 0, -1);
        nvec += 3;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_rem got=%b exp=0", out_valid);
        end
        if (out_lifm[0 +: W] !== 8'h98) begin
            nerr++;
            $display("FAIL b2b_res got=%h exp=98", out_lifm[0 +: W]);
        end
        if (out_lifm !== m_beat_lifm() || out_mt !== m_beat_mt()) begin
            nerr++;
            $display("FAIL b2b_resbeat got=%h exp=%h", out_lifm, m_beat_lifm());
        end
    endtask

    task automatic test_cnt_edges();
        do_reset();
        step(1, 0, 0, 0, -1);
        nvec += 2;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL cnt0_flags got=%b/%b exp=0/1", out_valid, in_ready);
        end
        if (out_lifm !== '0 || out_mt !== '0) begin
            nerr++;
            $display("FAIL cnt0_data got=%h exp=0", out_lifm);
        end
        step(1, 200, 0, 0, -1);
        nvec += 2;
        if (in_ready !== 1'b1 || out_cnt !== 6'd32) begin
            nerr++;
            $display("FAIL cnt200 got=%b/%0d exp=1/32", in_ready, out_cnt);
        end
        if (out_lifm !== m_beat_lifm() || out_mt !== m_beat_mt()) begin
            nerr++;
            $display("FAIL cnt200_beat got=%h exp=%h", out_lifm, m_beat_lifm());
        end
        step(1, 1, 0, 0, -1);
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL occ129_ready got=%b exp=0", in_ready);
        end
        step(1, 128, 0, 0, -1);
        repeat (4) step(0, 0, 1, 0, -1);
        nvec += 2;
        if (out_valid !== 1'b0 || out_cnt !== 6'd0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL occ1_flags got=%b/%0d/%b exp=0/0/1",
                     out_valid, out_cnt, in_ready);
        end
        if (out_lifm !== m_beat_lifm()) begin
            nerr++;
            $display("FAIL occ1_data got=%h exp=%h", out_lifm, m_beat_lifm());
        end
    endtask

`ifdef ZVC_PACKER_FLUSH_EN
    task automatic test_flush();
        logic [OW*W-1:0] t;
        do_reset();
        step(1, 5, 0, 0, -1);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL fl_pre got=%b exp=0", out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            step(k[0], 10, 0, 1, -1);
            t = out_lifm;
            t[5*W-1:0] = '0;
            nvec += 3;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                nerr++;
                $display("FAIL fl_flags cyc=%0d got=%b/%b exp=0/1",
                         k, in_ready, out_valid);
            end
            if (out_cnt !== 6'd5) begin
                nerr++;
                $display("FAIL fl_cnt cyc=%0d got=%0d exp=5", k, out_cnt);
            end
            if (t !== '0 || out_lifm !== m_beat_lifm()) begin
                nerr++;
                $display("FAIL fl_lanes cyc=%0d got=%h", k, out_lifm);
            end
        end
        step(0, 0, 1, 0, -1);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_lifm !== '0) begin
            nerr++;
            $display("FAIL fl_done got=%b/%b exp=1/0", in_ready, out_valid);
        end
        step(0, 0, 0, 1, -1);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL fl_empty got=%b/%b exp=1/0", in_ready, out_valid);
        end
    endtask
`endif

    task automatic test_random();
        bit iv, ordy, fl;
        int cnt;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 39) == 0);
            cnt  = ($urandom_range(0, 9) == 0) ? $urandom_range(129, 255)
                                               : $urandom_range(0, 128);
            step(iv, cnt, ordy, fl, -1);
            nvec += 5;
            if (out_valid !== m_val()) begin
                nerr++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m_val());
            end
            if (in_ready !== m_rdy()) begin
                nerr++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, m_rdy());
            end
            if (out_cnt !== m_cnt()) begin
                nerr++;
                $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, out_cnt, m_cnt());
            end
            if (out_lifm !== m_beat_lifm()) begin
                nerr++;
                $display("FAIL rnd_lifm cyc=%0d got=%h exp=%h", c, out_lifm, m_beat_lifm());
            end
            if (out_mt !== m_beat_mt()) begin
                nerr++;
                $display("FAIL rnd_mt cyc=%0d got=%h exp=%h", c, out_mt, m_beat_mt());
            end
        end
    endtask

    initial begin
        test_reset();
        test_concat();
        test_full();
        test_back_to_back();
        test_cnt_edges();
`ifdef ZVC_PACKER_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
